predelay_commutator: RTL and testbench

- Stage-front half of an R2MDC FFT inter-stage switch. Sits between butterfly stage k outputs and the next stage's post-commutator delay.
- Delays the lower butterfly output path by DELAY_CYCLES accepted samples.
- Routes the upper path and the delayed lower path onto two commutator output lanes. Routing swaps every DELAY_CYCLES accepted samples.
- Produces the lane ordering that the downstream post-delay (lane 0 delayed by DELAY_CYCLES, lane 1 direct) expects.

---
 rtl/predelay_commutator.sv | 130 +++++++++++++
 tb/tb_predelay_commutator.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/predelay_commutator.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : predelay_commutator
// Purpose  : Front half of an R2MDC inter-stage switch. The lower butterfly
//            output is delayed by DELAY_CYCLES accepted samples. That delayed
//            value and the undelayed upper output are then steered onto two
//            lanes. The routing flips every DELAY_CYCLES accepted samples.
// Ports    : CLK, RST (async, active-high)
//            in_valid                 - bf_out* pair present this cycle
//            bf_out0_re/_im           - upper butterfly output
//            bf_out1_re/_im           - lower butterfly output
//            cm_out0_re/_im, _valid   - commutator lane 0
//            cm_out1_re/_im, _valid   - commutator lane 1
//            cm_cross                 - routing used for current outputs
// Revision : 1.0 - initial release
// ============================================================================
module predelay_commutator #(
    parameter int DELAY_CYCLES = 16,
    parameter int DATA_W       = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] bf_out0_re,
    input  logic [DATA_W-1:0] bf_out0_im,
    input  logic [DATA_W-1:0] bf_out1_re,
    input  logic [DATA_W-1:0] bf_out1_im,
    output logic [DATA_W-1:0] cm_out0_re,
    output logic [DATA_W-1:0] cm_out0_im,
    output logic [DATA_W-1:0] cm_out1_re,
    output logic [DATA_W-1:0] cm_out1_im,
    output logic              cm_out0_valid,
    output logic              cm_out1_valid,
    output logic              cm_cross
);

    localparam int CNT_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DELAY_CYCLES - 1);

    // The sample counter doubles as the delay-line write pointer: both
    // advance once per accepted sample and wrap at DELAY_CYCLES-1.
    logic [CNT_W-1:0]    r_cnt;
    logic                r_cross;
    logic                r_primed;

    logic [2*DATA_W-1:0] w_upper;
    logic [2*DATA_W-1:0] w_lower;
    logic [2*DATA_W-1:0] w_delayed;
    logic                w_wrap;

    assign w_upper = {bf_out0_re, bf_out0_im};
    assign w_lower = {bf_out1_re, bf_out1_im};
    assign w_wrap  = (r_cnt == C_LAST);

    // ------------------------------------------------------------------
    // Delay line. Contents are never reset; r_primed marks them usable.
    // The entry under the pointer is read before being overwritten, which
    // yields exactly the lower sample from DELAY_CYCLES acceptances ago.
    // ------------------------------------------------------------------
    generate
        if (DELAY_CYCLES == 1) begin : g_depth_one
            logic [2*DATA_W-1:0] r_hold;

            always_ff @(posedge CLK) begin
                if (in_valid && !RST) begin
                    r_hold <= w_lower;
                end
            end

            assign w_delayed = r_hold;
        end else begin : g_depth_n
            logic [2*DATA_W-1:0] r_mem [DELAY_CYCLES];

            always_ff @(posedge CLK) begin
                if (in_valid && !RST) begin
                    r_mem[r_cnt] <= w_lower;
                end
            end

            assign w_delayed = r_mem[r_cnt];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control and registered outputs. Routing and the delayed-lane valid
    // use the switch/primed state as it stood before this edge.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt         <= '0;
            r_cross       <= 1'b0;
            r_primed      <= 1'b0;
            cm_out0_re    <= '0;
            cm_out0_im    <= '0;
            cm_out1_re    <= '0;
            cm_out1_im    <= '0;
            cm_out0_valid <= 1'b0;
            cm_out1_valid <= 1'b0;
            cm_cross      <= 1'b0;
        end else if (in_valid) begin
            if (w_wrap) begin
                r_cnt    <= '0;
                r_cross  <= ~r_cross;
                r_primed <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (!r_cross) begin
                {cm_out0_re, cm_out0_im} <= w_upper;
                {cm_out1_re, cm_out1_im} <= w_delayed;
                cm_out0_valid            <= 1'b1;
                cm_out1_valid            <= r_primed;
            end else begin
                {cm_out0_re, cm_out0_im} <= w_delayed;
                {cm_out1_re, cm_out1_im} <= w_upper;
                cm_out0_valid            <= r_primed;
                cm_out1_valid            <= 1'b1;
            end
            cm_cross <= r_cross;
        end else begin
            // Idle cycle: data and cm_cross hold, only the valids drop.
            cm_out0_valid <= 1'b0;
            cm_out1_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_predelay_commutator.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_predelay_commutator
// Purpose  : Self-checking bench for predelay_commutator at DELAY_CYCLES of
//            4, 1 and 16. It uses directed vector tables, an asynchronous
//            reset sequence, full-scale data, and a random stream checked
//            against a sample-index reference model and a cascaded
//            post-delay pairing check.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_predelay_commutator;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- DELAY_CYCLES = 4 ----------------
    logic         rst4, v4;
    logic [W-1:0] a4re, a4im, b4re, b4im;
    logic [W-1:0] o4_0re, o4_0im, o4_1re, o4_1im;
    logic         o4v0, o4v1, o4x;

    predelay_commutator #(.DELAY_CYCLES(4), .DATA_W(W)) u_d4 (
        .CLK(clk), .RST(rst4), .in_valid(v4),
        .bf_out0_re(a4re), .bf_out0_im(a4im), .bf_out1_re(b4re), .bf_out1_im(b4im),
        .cm_out0_re(o4_0re), .cm_out0_im(o4_0im), .cm_out1_re(o4_1re), .cm_out1_im(o4_1im),
        .cm_out0_valid(o4v0), .cm_out1_valid(o4v1), .cm_cross(o4x)
    );

    // ---------------- DELAY_CYCLES = 1 ----------------
    logic         rst1, v1;
    logic [W-1:0] a1re, a1im, b1re, b1im;
    logic [W-1:0] o1_0re, o1_0im, o1_1re, o1_1im;
    logic         o1v0, o1v1, o1x;

    predelay_commutator #(.DELAY_CYCLES(1), .DATA_W(W)) u_d1 (
        .CLK(clk), .RST(rst1), .in_valid(v1),
        .bf_out0_re(a1re), .bf_out0_im(a1im), .bf_out1_re(b1re), .bf_out1_im(b1im),
        .cm_out0_re(o1_0re), .cm_out0_im(o1_0im), .cm_out1_re(o1_1re), .cm_out1_im(o1_1im),
        .cm_out0_valid(o1v0), .cm_out1_valid(o1v1), .cm_cross(o1x)
    );

    // ---------------- DELAY_CYCLES = 16 ----------------
    logic         rst16, v16;
    logic [W-1:0] a16re, a16im, b16re, b16im;
    logic [W-1:0] o16_0re, o16_0im, o16_1re, o16_1im;
    logic         o16v0, o16v1, o16x;

    predelay_commutator #(.DELAY_CYCLES(16), .DATA_W(W)) u_d16 (
        .CLK(clk), .RST(rst16), .in_valid(v16),
        .bf_out0_re(a16re), .bf_out0_im(a16im), .bf_out1_re(b16re), .bf_out1_im(b16im),
        .cm_out0_re(o16_0re), .cm_out0_im(o16_0im), .cm_out1_re(o16_1re), .cm_out1_im(o16_1im),
        .cm_out0_valid(o16v0), .cm_out1_valid(o16v1), .cm_cross(o16x)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One record per cycle. c0/c1 say whether lane data is known and must be compared.
    typedef struct {
        logic         v;
        logic [W-1:0] a, b;
        logic [W-1:0] e0, e1;
        logic         ev0, ev1, ex;
        logic         c0, c1;
    } vec_t;

    vec_t tab1[12];
    vec_t tab2[24];

    task automatic apply4(input vec_t t, input string tag, input int idx);
        logic [W-1:0] ni0, ni1;
        v4   = t.v;
        a4re = t.a;
        a4im = -t.a;
        b4re = t.b;
        b4im = -t.b;
        ni0  = -t.e0;
        ni1  = -t.e1;
        @(posedge clk);
        #1;
        chk($sformatf("%s[%0d].valid0", tag, idx), 32'(o4v0), 32'(t.ev0));
        chk($sformatf("%s[%0d].valid1", tag, idx), 32'(o4v1), 32'(t.ev1));
        chk($sformatf("%s[%0d].cross", tag, idx), 32'(o4x), 32'(t.ex));
        if (t.c0) chk($sformatf("%s[%0d].lane0", tag, idx), {o4_0re, o4_0im}, {t.e0, ni0});
        if (t.c1) chk($sformatf("%s[%0d].lane1", tag, idx), {o4_1re, o4_1im}, {t.e1, ni1});
    endtask

    task automatic reset4();
        rst4 = 1'b1;
        v4   = 1'b0;
        @(posedge clk);
        #1;
        rst4 = 1'b0;
    endtask

    // Random-stream records for the D=16 instance, indexed by accepted sample.
    logic [2*W-1:0] ra[1000], rb[1000], r0[1000], r1[1000];

    initial begin
        int blk;
        vec_t t;
        rst4 = 1'b1; rst1 = 1'b1; rst16 = 1'b1;
        v4 = 1'b0; v1 = 1'b0; v16 = 1'b0;
        a4re = '0; a4im = '0; b4re = '0; b4im = '0;
        a1re = '0; a1im = '0; b1re = '0; b1im = '0;
        a16re = '0; a16im = '0; b16re = '0; b16im = '0;

        // Expected response from the DELAY_CYCLES=4 stream a_n=n, b_n=100+n.
        for (int n = 0; n < 12; n++) begin
            blk = n / 4;
            tab1[n].v = 1'b1;
            tab1[n].a = W'(n);
            tab1[n].b = W'(100 + n);
            tab1[n].ex = blk[0];
            tab1[n].ev0 = 1'b1;
            tab1[n].ev1 = (blk != 0);
            if (blk == 1) begin
                tab1[n].e0 = W'(100 + n - 4);
                tab1[n].e1 = W'(n);
            end else begin
                tab1[n].e0 = W'(n);
                tab1[n].e1 = W'(100 + n - 4);
            end
            tab1[n].c0 = tab1[n].ev0;
            tab1[n].c1 = tab1[n].ev1;
        end
        // Same stream with an idle cycle after every sample.
        for (int i = 0; i < 12; i++) begin
            tab2[2*i]       = tab1[i];
            tab2[2*i+1]     = tab1[i];
            tab2[2*i+1].v   = 1'b0;
            tab2[2*i+1].a   = 16'hDEAD;
            tab2[2*i+1].b   = 16'hBEEF;
            tab2[2*i+1].ev0 = 1'b0;
            tab2[2*i+1].ev1 = 1'b0;
        end

        // Reset state, with no clock edge yet.
        #1;
        chk("reset.lane0", {o4_0re, o4_0im}, 32'h0);
        chk("reset.lane1", {o4_1re, o4_1im}, 32'h0);
        chk("reset.flags", {29'h0, o4v0, o4v1, o4x}, 32'h0);
        @(posedge clk);
        #1;
        rst4 = 1'b0; rst1 = 1'b0; rst16 = 1'b0;

        // Scenario 1: continuous stream.
        for (int i = 0; i < 12; i++) apply4(tab1[i], "cont", i);

        // Scenario 2: alternate idle cycles.
        reset4();
        for (int i = 0; i < 24; i++) apply4(tab2[i], "gap", i);

        // Scenario 3: async reset in the middle of a cycle, after sample 6.
        reset4();
        for (int i = 0; i < 7; i++) apply4(tab1[i], "pre", i);
        #3;
        rst4 = 1'b1;
        v4   = 1'b1;              // this sample must be dropped
        #1;
        chk("async.lane0", {o4_0re, o4_0im}, 32'h0);
        chk("async.lane1", {o4_1re, o4_1im}, 32'h0);
        chk("async.flags", {29'h0, o4v0, o4v1, o4x}, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_wins.flags", {29'h0, o4v0, o4v1, o4x}, 32'h0);
        rst4 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            t = tab1[i];
            t.a  = t.a + 16'd200;
            t.b  = t.b + 16'd200;
            t.e0 = t.e0 + 16'd200;
            t.e1 = t.e1 + 16'd200;
            apply4(t, "restart", i);
        end
        v4 = 1'b0;

        // DELAY_CYCLES=1 with full-scale values.
        begin
            logic [W-1:0] pa_re[8], pa_im[8], pb_re[8], pb_im[8];
            logic [2*W-1:0] up, ld, l0, l1;
            for (int n = 0; n < 8; n++) begin
                pa_re[n] = n[0] ? 16'h8000 : 16'h7FFF;
                pa_im[n] = ~pa_re[n];
                pb_re[n] = n[1] ? 16'h7FFF : 16'h8000;
                pb_im[n] = ~pb_re[n];
                v1 = 1'b1;
                a1re = pa_re[n]; a1im = pa_im[n];
                b1re = pb_re[n]; b1im = pb_im[n];
                @(posedge clk);
                #1;
                up = {pa_re[n], pa_im[n]};
                chk($sformatf("d1[%0d].cross", n), 32'(o1x), 32'(n % 2));
                l0 = {o1_0re, o1_0im};
                l1 = {o1_1re, o1_1im};
                if (n % 2 == 0) begin
                    chk($sformatf("d1[%0d].upper", n), l0, up);
                    chk($sformatf("d1[%0d].valids", n), {o1v0, o1v1}, {1'b1, n != 0});
                end else begin
                    chk($sformatf("d1[%0d].upper", n), l1, up);
                    chk($sformatf("d1[%0d].valids", n), {o1v0, o1v1}, 2'b11);
                end
                if (n > 0) begin
                    ld = {pb_re[n-1], pb_im[n-1]};
                    chk($sformatf("d1[%0d].delayed", n), (n % 2 == 0) ? l1 : l0, ld);
                end
            end
            v1 = 1'b0;
        end

        // DELAY_CYCLES=16: random stream with random gaps against the model.
        begin
            int n;
            logic [2*W-1:0] up, ld, last0;
            logic last_x, xx;
            n = 0;
            last0 = '0;
            last_x = 1'b0;
            for (int cyc = 0; cyc < 5000 && n < 1000; cyc++) begin
                v16 = ($urandom_range(0, 3) != 0);
                a16re = W'($urandom); a16im = W'($urandom);
                b16re = W'($urandom); b16im = W'($urandom);
                if (v16) begin
                    ra[n] = {a16re, a16im};
                    rb[n] = {b16re, b16im};
                end
                @(posedge clk);
                #1;
                if (v16) begin
                    xx = ((n / 16) % 2) == 1;
                    up = ra[n];
                    chk($sformatf("rnd[%0d].cross", n), 32'(o16x), 32'(xx));
                    chk($sformatf("rnd[%0d].valids", n), {o16v0, o16v1},
                        xx ? {n >= 16, 1'b1} : {1'b1, n >= 16});
                    chk($sformatf("rnd[%0d].upper", n), xx ? {o16_1re, o16_1im} : {o16_0re, o16_0im}, up);
                    if (n >= 16) begin
                        ld = rb[n-16];
                        chk($sformatf("rnd[%0d].delayed", n), xx ? {o16_0re, o16_0im} : {o16_1re, o16_1im}, ld);
                    end
                    r0[n] = {o16_0re, o16_0im};
                    r1[n] = {o16_1re, o16_1im};
                    last0 = {o16_0re, o16_0im};
                    last_x = xx;
                    n++;
                end else begin
                    chk("rnd.idle_valids", {o16v0, o16v1}, 2'b00);
                    chk("rnd.idle_hold", {o16_0re, o16_0im}, last0);
                    chk("rnd.idle_cross", 32'(o16x), 32'(last_x));
                end
            end
            v16 = 1'b0;
            chk("rnd.sample_count", n, 1000);

            // Post-delay cascade: lane 0 delayed by 16 samples, lane 1 direct.
            for (int k = 16; k < n; k++) begin
                if (((k / 16) % 2) == 1) begin
                    chk($sformatf("pair_a[%0d].first", k), r0[k-16], ra[k-16]);
                    chk($sformatf("pair_a[%0d].second", k), r1[k], ra[k]);
                end else if (k >= 32) begin
                    chk($sformatf("pair_b[%0d].first", k), r0[k-16], rb[k-32]);
                    chk($sformatf("pair_b[%0d].second", k), r1[k], rb[k-16]);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
